// File: rtl/delay_cal_pkg.sv
// rtl/delay_cal_pkg.sv - shared definitions for the delay-line tap calibrator
// Purpose: FSM state encoding, tap-range constants and the tap clamp helper
//          used by every driver of the pixel-array delay line.
// Ports:   none (package).
package delay_cal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL
    } cal_state_t;

    localparam int         NUM_TAPS = 6;
    localparam logic [2:0] MAX_TAP  = 3'd5;

    // Codes 6 and 7 do not exist on the delay line; pin them to the last tap.
    function automatic logic [2:0] clamp_tap(input logic [2:0] tap);
        return (tap > MAX_TAP) ? MAX_TAP : tap;
    endfunction

endpackage

// File: rtl/tap_majority_counter.sv
// rtl/tap_majority_counter.sv - ones counter with strict-majority decision
// Purpose: counts high samples of the delayed signal while enabled and reports
//          whether strictly more than half of SAMPLE_CYCLES samples were high.
// Ports:   clk, rst_n (async, active-low), clear, enable, sample (data bit),
//          ones (running count), majority (ones*2 > SAMPLE_CYCLES).
module tap_majority_counter #(
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             enable,
    input  logic                             sample,
    output logic [$clog2(SAMPLE_CYCLES):0]   ones,
    output logic                             majority
);

    localparam int         CW         = $clog2(SAMPLE_CYCLES) + 1;
    localparam logic [CW:0] LIMIT     = (CW + 1)'(SAMPLE_CYCLES);

    // One extra bit lets the count reach SAMPLE_CYCLES without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
        end else if (clear) begin
            ones <= '0;
        end else if (enable && sample) begin
            ones <= ones + 1'b1;
        end
    end

    // A tie (exactly half high) resolves to 0.
    assign majority = ({ones, 1'b0} > LIMIT);

endmodule

// File: rtl/delay_tap_calibrator.sv
// rtl/delay_tap_calibrator.sv - delay-line tap sweep and lock controller
// Purpose: on Start sweeps taps 0-5, majority-samples the delayed signal per tap
//          and locks to the first tap whose level differs from tap 0. When idle,
//          drives the locked tap or a clamped manual override.
// Ports:   Clk, ResetB (async, active-low), Start, ManualEn, ManualSelect[2:0],
//          DelayedSample, Select[2:0], Busy, Done, Found, CalSelect[2:0].
module delay_tap_calibrator
    import delay_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       ResetB,
    input  logic       Start,
    input  logic       ManualEn,
    input  logic [2:0] ManualSelect,
    input  logic       DelayedSample,
    output logic [2:0] Select,
    output logic       Busy,
    output logic       Done,
    output logic       Found,
    output logic [2:0] CalSelect
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);

    cal_state_t state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [2:0] tap, tap_next;
    logic       ref_level, ref_level_next;
    logic       done_next, found_next;
    logic [2:0] cal_next, select_next;
    logic       busy_next;
    logic       majority;
    logic [$clog2(SAMPLE_CYCLES):0] ones;

    // The ones counter is held clear for the whole settle window, so it is
    // zero on the first SAMPLE cycle and complete by the EVAL cycle.
    tap_majority_counter #(
        .SAMPLE_CYCLES(SAMPLE_CYCLES)
    ) u_majority (
        .clk      (Clk),
        .rst_n    (ResetB),
        .clear    (state == ST_SETTLE),
        .enable   (state == ST_SAMPLE),
        .sample   (DelayedSample),
        .ones     (ones),
        .majority (majority)
    );

    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tap       <= '0;
            ref_level <= 1'b0;
            Done      <= 1'b0;
            Found     <= 1'b0;
            CalSelect <= '0;
            Select    <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            tap       <= tap_next;
            ref_level <= ref_level_next;
            Done      <= done_next;
            Found     <= found_next;
            CalSelect <= cal_next;
            Select    <= select_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        tap_next       = tap;
        ref_level_next = ref_level;
        done_next      = Done;
        found_next     = Found;
        cal_next       = CalSelect;

        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                    tap_next   = '0;
                    done_next  = 1'b0;
                    found_next = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_next = ST_SAMPLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (cnt == SAMPLE_LAST) begin
                    state_next = ST_EVAL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_EVAL: begin
                if (tap == 3'd0) begin
                    ref_level_next = majority;
                    tap_next       = 3'd1;
                    state_next     = ST_SETTLE;
                end else if (majority != ref_level) begin
                    cal_next   = tap;
                    found_next = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (tap == MAX_TAP) begin
                    cal_next   = 3'd0;
                    found_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tap_next   = tap + 3'd1;
                    state_next = ST_SETTLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Select is computed from next-state values so that the sweep tap,
        // and at sweep end the idle source, appear on the same edge as Busy.
        busy_next = (state_next != ST_IDLE);
        if (busy_next) begin
            select_next = tap_next;
        end else if (ManualEn) begin
            select_next = clamp_tap(ManualSelect);
        end else begin
            select_next = cal_next;
        end
    end

    assign Busy = (state != ST_IDLE);

endmodule
